// File: rtl/flash_ahb_master_if.sv
// rtl/flash_ahb_master_if.sv - AHB-Lite bus between the flash master and the FIC_0 slave
// Purpose: bundles the AHB-Lite master request signals and the slave responses.
// Ports (master view):
//   out: FIC_0_AHB_S_HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[1:0], HWDATA[31:0],
//        HMASTLOCK, HREADY
//   in : FIC_0_AHB_S_HRDATA[31:0], HREADYOUT, HRESP
interface flash_ahb_master_if;
   logic        FIC_0_AHB_S_HSEL;
   logic [31:0] FIC_0_AHB_S_HADDR;
   logic [1:0]  FIC_0_AHB_S_HTRANS;
   logic        FIC_0_AHB_S_HWRITE;
   logic [1:0]  FIC_0_AHB_S_HSIZE;
   logic [31:0] FIC_0_AHB_S_HWDATA;
   logic        FIC_0_AHB_S_HMASTLOCK;
   logic        FIC_0_AHB_S_HREADY;
   logic [31:0] FIC_0_AHB_S_HRDATA;
   logic        FIC_0_AHB_S_HREADYOUT;
   logic        FIC_0_AHB_S_HRESP;

   modport master (
      output FIC_0_AHB_S_HSEL, FIC_0_AHB_S_HADDR, FIC_0_AHB_S_HTRANS, FIC_0_AHB_S_HWRITE,
             FIC_0_AHB_S_HSIZE, FIC_0_AHB_S_HWDATA, FIC_0_AHB_S_HMASTLOCK, FIC_0_AHB_S_HREADY,
      input  FIC_0_AHB_S_HRDATA, FIC_0_AHB_S_HREADYOUT, FIC_0_AHB_S_HRESP
   );

   modport slave (
      input  FIC_0_AHB_S_HSEL, FIC_0_AHB_S_HADDR, FIC_0_AHB_S_HTRANS, FIC_0_AHB_S_HWRITE,
             FIC_0_AHB_S_HSIZE, FIC_0_AHB_S_HWDATA, FIC_0_AHB_S_HMASTLOCK, FIC_0_AHB_S_HREADY,
      output FIC_0_AHB_S_HRDATA, FIC_0_AHB_S_HREADYOUT, FIC_0_AHB_S_HRESP
   );
endinterface

// File: rtl/flash_ahb_master.sv
// rtl/flash_ahb_master.sv - single-outstanding CPU to AHB-Lite master for the eNVM window
// Purpose: accepts one CPU access at a time, rejects illegal size/alignment combinations
//          locally, and runs a single NONSEQ transfer on the FIC_0 AHB-Lite slave.
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   mss_ready                flash subsystem ready; gates new grants only
//   cpu_req/we/size/addr/wdata  CPU request
//   cpu_gnt                  combinational accept
//   cpu_rvalid/rdata/err     one-cycle completion with read data and error flag
//   ahb                      AHB-Lite master modport
module flash_ahb_master #(
   parameter logic [31:0] FLASH_BASE = 32'h6000_0000,
   parameter int          OFFSET_W   = 18
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                mss_ready,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [1:0]          cpu_size,
   input  logic [OFFSET_W-1:0] cpu_addr,
   input  logic [31:0]         cpu_wdata,
   output logic                cpu_gnt,
   output logic                cpu_rvalid,
   output logic [31:0]         cpu_rdata,
   output logic                cpu_err,
   flash_ahb_master_if.master  ahb
);

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR, ST_BAD} state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t      state_q, state_d;
   logic        hsel_q, hsel_d;
   logic [1:0]  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic [1:0]  hsize_q, hsize_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic        rvalid_q, rvalid_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        illegal;

   assign illegal = (cpu_size == 2'd3) ||
                    (cpu_size == 2'd1 && cpu_addr[0]) ||
                    (cpu_size == 2'd2 && cpu_addr[1:0] != 2'b00);

   assign cpu_gnt = (state_q == ST_IDLE) && mss_ready && cpu_req;

   always_comb begin
      state_d  = state_q;
      hsel_d   = hsel_q;
      htrans_d = htrans_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hwdata_d = hwdata_q;
      // Completion outputs are pulses: they fall back to zero unless set below.
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdata_d  = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_gnt) begin
               haddr_d  = FLASH_BASE | 32'(cpu_addr);
               hwrite_d = cpu_we;
               hsize_d  = cpu_size;
               hwdata_d = cpu_wdata;
               if (illegal) begin
                  // Response is raised at the grant edge so it shows one cycle later.
                  state_d  = ST_BAD;
                  rvalid_d = 1'b1;
                  err_d    = 1'b1;
               end else begin
                  state_d  = ST_ADDR;
                  hsel_d   = 1'b1;
                  htrans_d = HTRANS_NONSEQ;
               end
            end
         end
         ST_ADDR: begin
            if (ahb.FIC_0_AHB_S_HREADYOUT) begin
               state_d  = ST_DATA;
               hsel_d   = 1'b0;
               htrans_d = HTRANS_IDLE;
            end
         end
         ST_DATA: begin
            if (ahb.FIC_0_AHB_S_HRESP) begin
               // A single-cycle error (HREADYOUT already high) is closed out directly.
               if (ahb.FIC_0_AHB_S_HREADYOUT) begin
                  state_d  = ST_IDLE;
                  rvalid_d = 1'b1;
                  err_d    = 1'b1;
               end else begin
                  state_d = ST_ERR;
               end
            end else if (ahb.FIC_0_AHB_S_HREADYOUT) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b1;
               rdata_d  = hwrite_q ? 32'h0 : ahb.FIC_0_AHB_S_HRDATA;
            end
         end
         ST_ERR: begin
            if (ahb.FIC_0_AHB_S_HREADYOUT) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b1;
               err_d    = 1'b1;
            end
         end
         ST_BAD:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         hsel_q   <= 1'b0;
         htrans_q <= HTRANS_IDLE;
         haddr_q  <= FLASH_BASE;
         hwrite_q <= 1'b0;
         hsize_q  <= 2'd0;
         hwdata_q <= 32'h0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         hsel_q   <= hsel_d;
         htrans_q <= htrans_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hwdata_q <= hwdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign cpu_rvalid = rvalid_q;
   assign cpu_err    = err_q;
   assign cpu_rdata  = rdata_q;

   assign ahb.FIC_0_AHB_S_HSEL      = hsel_q;
   assign ahb.FIC_0_AHB_S_HTRANS    = htrans_q;
   assign ahb.FIC_0_AHB_S_HADDR     = haddr_q;
   assign ahb.FIC_0_AHB_S_HWRITE    = hwrite_q;
   assign ahb.FIC_0_AHB_S_HSIZE     = hsize_q;
   assign ahb.FIC_0_AHB_S_HWDATA    = hwdata_q;
   assign ahb.FIC_0_AHB_S_HMASTLOCK = 1'b0;
   // Only one slave hangs off this master, so its ready is the bus ready.
   assign ahb.FIC_0_AHB_S_HREADY    = ahb.FIC_0_AHB_S_HREADYOUT;

endmodule

// File: tb/tb_flash_ahb_master.sv
// tb/tb_flash_ahb_master.sv - scoreboard bench for flash_ahb_master with a planned AHB slave
module tb_flash_ahb_master;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] haddr;
      logic        hwrite;
      logic [1:0]  hsize;
      logic [31:0] wdata;
      int          aw;
      int          dw;
      int          ek;     // 0 ok, 1 two-cycle error, 2 single-cycle error
      logic [31:0] rdata;
   } plan_t;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        mss_ready, cpu_req, cpu_we;
   logic [1:0]  cpu_size;
   logic [17:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_gnt, cpu_rvalid, cpu_err;
   logic [31:0] cpu_rdata;

   flash_ahb_master_if bus ();

   flash_ahb_master dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .mss_ready  (mss_ready),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_size   (cpu_size),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .ahb        (bus)
   );

   always #5 HCLK = ~HCLK;

   exp_t  exp_q[$];
   plan_t plan_q[$];
   int    gnt_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    last_gnt_cyc = -1;
   int    last_rv_cyc = -1;
   int    s_phase = 0;

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_htrans"}, 32'(bus.FIC_0_AHB_S_HTRANS), 0);
      chk({tag, "_hsel"},   32'(bus.FIC_0_AHB_S_HSEL), 0);
      chk({tag, "_haddr"},  bus.FIC_0_AHB_S_HADDR, 32'h6000_0000);
      chk({tag, "_hwrite"}, 32'(bus.FIC_0_AHB_S_HWRITE), 0);
      chk({tag, "_hsize"},  32'(bus.FIC_0_AHB_S_HSIZE), 0);
      chk({tag, "_hwdata"}, bus.FIC_0_AHB_S_HWDATA, 0);
      chk({tag, "_rvalid"}, 32'(cpu_rvalid), 0);
      chk({tag, "_err"},    32'(cpu_err), 0);
      chk({tag, "_rdata"},  cpu_rdata, 0);
      chk({tag, "_gnt"},    32'(cpu_gnt), 0);
   endtask

   // Slave: follows the plan queued for each legal request, checks the address and data
   // phases it sees, and answers with the planned wait states / error / read data.
   initial begin : slave
      plan_t cur;
      int    cnt;
      cnt = 0;
      bus.FIC_0_AHB_S_HREADYOUT = 1'b1;
      bus.FIC_0_AHB_S_HRESP     = 1'b0;
      bus.FIC_0_AHB_S_HRDATA    = 32'h0;
      forever begin
         @(posedge HCLK);
         #1;
         if (!HRESETn) begin
            s_phase = 0;
            bus.FIC_0_AHB_S_HREADYOUT = 1'b1;
            bus.FIC_0_AHB_S_HRESP     = 1'b0;
            continue;
         end
         if (s_phase == 1 && bus.FIC_0_AHB_S_HREADYOUT) begin
            s_phase = 2;
            cnt = 0;
         end else if (s_phase == 2 && bus.FIC_0_AHB_S_HREADYOUT) begin
            s_phase = 0;
         end
         if (s_phase == 0 && bus.FIC_0_AHB_S_HTRANS == 2'b10) begin
            chk("nonseq_expected", 32'(plan_q.size() != 0), 1);
            if (plan_q.size() != 0) begin
               cur = plan_q.pop_front();
               s_phase = 1;
               cnt = 0;
            end
         end
         bus.FIC_0_AHB_S_HRESP  = 1'b0;
         bus.FIC_0_AHB_S_HRDATA = $urandom;
         case (s_phase)
            1: begin
               chk("addr_htrans", 32'(bus.FIC_0_AHB_S_HTRANS), 2);
               chk("addr_hsel",   32'(bus.FIC_0_AHB_S_HSEL), 1);
               chk("addr_haddr",  bus.FIC_0_AHB_S_HADDR, cur.haddr);
               chk("addr_hwrite", 32'(bus.FIC_0_AHB_S_HWRITE), 32'(cur.hwrite));
               chk("addr_hsize",  32'(bus.FIC_0_AHB_S_HSIZE), 32'(cur.hsize));
               bus.FIC_0_AHB_S_HREADYOUT = (cnt >= cur.aw);
               cnt++;
            end
            2: begin
               chk("data_htrans", 32'(bus.FIC_0_AHB_S_HTRANS), 0);
               chk("data_hsel",   32'(bus.FIC_0_AHB_S_HSEL), 0);
               chk("data_haddr",  bus.FIC_0_AHB_S_HADDR, cur.haddr);
               if (cur.hwrite) chk("data_hwdata", bus.FIC_0_AHB_S_HWDATA, cur.wdata);
               if (cnt < cur.dw) begin
                  bus.FIC_0_AHB_S_HREADYOUT = 1'b0;
               end else if (cur.ek == 0) begin
                  bus.FIC_0_AHB_S_HREADYOUT = 1'b1;
                  bus.FIC_0_AHB_S_HRDATA    = cur.rdata;
               end else if (cur.ek == 2 || cnt > cur.dw) begin
                  bus.FIC_0_AHB_S_HREADYOUT = 1'b1;
                  bus.FIC_0_AHB_S_HRESP     = 1'b1;
               end else begin
                  bus.FIC_0_AHB_S_HREADYOUT = 1'b0;
                  bus.FIC_0_AHB_S_HRESP     = 1'b1;
               end
               cnt++;
            end
            default: bus.FIC_0_AHB_S_HREADYOUT = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every completion pulse.
   always @(negedge HCLK) begin
      exp_t e;
      int   g;
      if (HRESETn) begin
         chk("hmastlock", 32'(bus.FIC_0_AHB_S_HMASTLOCK), 0);
         chk("hready", 32'(bus.FIC_0_AHB_S_HREADY), 32'(bus.FIC_0_AHB_S_HREADYOUT));
         if (!mss_ready) chk("gnt_while_not_ready", 32'(cpu_gnt), 0);
         if (cpu_gnt) begin
            gnt_q.push_back(cyc);
            last_gnt_cyc = cyc;
         end
         if (cpu_rvalid) begin
            if (exp_q.size() == 0 || gnt_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               g = gnt_q.pop_front();
               chk("rsp_err", 32'(cpu_err), 32'(e.err));
               chk("rsp_rdata", cpu_rdata, e.rdata);
               chk("rsp_latency", 32'(cyc - g), 32'(e.lat));
               last_rv_cyc = cyc;
            end
         end
      end
   end

   // Issues one request, returns once it is granted (or the wait expires).
   task automatic do_req(input logic we, input logic [1:0] size, input logic [17:0] addr,
                         input logic [31:0] wdata, input int aw, input int dw, input int ek,
                         input logic [31:0] rd);
      exp_t  e;
      plan_t p;
      bit    illegal;
      int    n;
      illegal = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
      e.err   = illegal || ek != 0;
      e.rdata = (illegal || ek != 0 || we) ? 32'h0 : rd;
      e.lat   = illegal ? 1 : aw + 2 + dw + ((ek == 1) ? 2 : 1);
      p.haddr = 32'h6000_0000 + 32'(addr);
      p.hwrite = we;
      p.hsize = size;
      p.wdata = wdata;
      p.aw = aw;
      p.dw = dw;
      p.ek = ek;
      p.rdata = rd;
      @(posedge HCLK);
      #1;
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_size = size;
      cpu_addr = addr;
      cpu_wdata = wdata;
      n = 0;
      forever begin
         @(negedge HCLK);
         if (cpu_gnt) break;
         n++;
         if (n > 300) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=0 required=1 at cycle %0d", cyc);
            cpu_req = 1'b0;
            return;
         end
      end
      exp_q.push_back(e);
      if (!illegal) plan_q.push_back(p);
      @(posedge HCLK);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0) begin
         @(negedge HCLK);
         n++;
         if (n > 400) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout actual=%0d required=0 pending", exp_q.size());
            exp_q.delete();
            break;
         end
      end
      @(posedge HCLK);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0]  sz;
      logic [17:0] a;
      int          r, ek, n;
      HRESETn = 1'b0;
      mss_ready = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_size = 2'd0;
      cpu_addr = 18'h0;
      cpu_wdata = 32'h0;
      repeat (3) @(posedge HCLK);
      #1;
      reset_checks("reset");
      @(negedge HCLK);
      #1;
      HRESETn = 1'b1;
      mss_ready = 1'b1;

      // Word read, zero waits
      do_req(1'b0, 2'd2, 18'h100, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
      wait_idle();
      // Halfword write, three data-phase waits
      do_req(1'b1, 2'd1, 18'h2, 32'h0000_1234, 0, 3, 0, 32'h0);
      wait_idle();
      // Misaligned word
      do_req(1'b0, 2'd2, 18'h3, 32'h0, 0, 0, 0, 32'h0);
      wait_idle();
      // Two-cycle error followed immediately by another request
      do_req(1'b0, 2'd2, 18'h10, 32'h0, 0, 0, 1, 32'h1234_5678);
      do_req(1'b0, 2'd0, 18'h11, 32'h0, 0, 0, 0, 32'h0000_0055);
      chk("grant_after_error", 32'(last_gnt_cyc), 32'(last_rv_cyc));
      wait_idle();
      // Single-cycle error
      do_req(1'b1, 2'd0, 18'h7, 32'hAB, 1, 1, 2, 32'h0);
      wait_idle();

      // mss_ready low blocks grants; rising edge grants in the same cycle
      mss_ready = 1'b0;
      fork
         do_req(1'b0, 2'd2, 18'h200, 32'h0, 0, 0, 0, 32'hCAFE_0001);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge HCLK);
               chk("blocked_gnt", 32'(cpu_gnt), 0);
               chk("blocked_htrans", 32'(bus.FIC_0_AHB_S_HTRANS), 0);
            end
            @(posedge HCLK);
            #1;
            mss_ready = 1'b1;
            @(negedge HCLK);
            chk("gnt_on_ready_rise", 32'(cpu_gnt), 1);
         end
      join
      wait_idle();

      // Reset in the middle of a stalled data phase
      do_req(1'b0, 2'd2, 18'h40, 32'h0, 0, 30, 0, 32'h1111_2222);
      n = 0;
      while (s_phase != 2 && n < 20) begin
         @(posedge HCLK);
         #2;
         n++;
      end
      chk("reached_data_phase", 32'(s_phase), 2);
      @(posedge HCLK);
      #3;
      HRESETn = 1'b0;
      exp_q.delete();
      gnt_q.delete();
      plan_q.delete();
      #1;
      reset_checks("async_reset");
      repeat (2) @(negedge HCLK);
      #1;
      HRESETn = 1'b1;
      repeat (5) @(posedge HCLK);
      #1;
      do_req(1'b0, 2'd2, 18'h44, 32'h0, 0, 0, 0, 32'h3333_4444);
      wait_idle();

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom_range(0, 3));
         a = 18'($urandom);
         if ($urandom_range(0, 3) != 0) a = a & 18'h3FFFC;
         r = $urandom_range(0, 9);
         ek = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         do_req(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(0, 2),
                $urandom_range(0, 3), ek, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            mss_ready = 1'b0;
            repeat ($urandom_range(1, 5)) @(posedge HCLK);
            #1;
            mss_ready = 1'b1;
         end
         if ($urandom_range(0, 1) == 0) wait_idle();
      end
      wait_idle();
      repeat (3) @(posedge HCLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flash_ahb_master.md
FLASH_AHB_MASTER -- requirements
Module: flash_ahb_master

Interface
REQ-001 Parameter FLASH_BASE, default 32'h6000_0000; AHB base address of the eNVM window.
REQ-002 Parameter OFFSET_W, default 18; width of the CPU byte offset into the window.
REQ-003 HCLK  in  1  Clock; the same net as the MSS FIC_0 clock.
REQ-004 HRESETn  in  1  Reset; asynchronous, active-low.
REQ-005 mss_ready  in  1  MSS_READY from the flash subsystem; no request is granted while it is low.
REQ-006 cpu_req  in  1  CPU request valid.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-009 cpu_addr  in  OFFSET_W  Byte offset into the window.
REQ-010 cpu_wdata  in  32  Write data.
REQ-011 cpu_gnt  out  1  Request accepted this cycle (combinational).
REQ-012 cpu_rvalid  out  1  One-cycle completion pulse.
REQ-013 cpu_rdata  out  32  Read data; valid with cpu_rvalid.
REQ-014 cpu_err  out  1  Error flag; valid with cpu_rvalid.
REQ-015 FIC_0_AHB_S_HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[1:0], HWDATA[31:0], HMASTLOCK, HREADY  out  AHB-Lite master signals to the FIC_0 slave.
REQ-016 FIC_0_AHB_S_HRDATA[31:0], HREADYOUT, HRESP  in  Slave response signals.

Function
REQ-017 The block SHALL be an FSM with states IDLE, ADDR, DATA, ERR, and BAD, and SHALL allow one outstanding transfer.
REQ-018 cpu_gnt SHALL equal (state==IDLE) & mss_ready & cpu_req.
REQ-019 On grant, the block SHALL register we, size, wdata and HADDR = FLASH_BASE | zero-extended cpu_addr.
- If the request is illegal, next state is BAD.
- Otherwise, next state is ADDR.
REQ-020 A request SHALL be illegal if any of the following holds:
- cpu_size==3;
- cpu_size==1 and addr[0]==1;
- cpu_size==2 and addr[1:0]!=0.
REQ-021 BAD SHALL pulse cpu_rvalid=1 with cpu_err=1 and cpu_rdata=0, issue no AHB transfer, and return to IDLE.
REQ-022 In ADDR the block SHALL drive the address phase: HSEL=1, HTRANS=2'b10 (NONSEQ), and HADDR/HWRITE/HSIZE from the registers.
- It SHALL hold these until HREADYOUT=1, then go to DATA.
REQ-023 In DATA, ERR, and IDLE the block SHALL drive HTRANS=2'b00 and HSEL=0; HADDR/HWRITE/HSIZE SHALL hold their last values.
REQ-024 In DATA, HWDATA SHALL carry the registered wdata; HWDATA SHALL hold stable until the data phase completes.
REQ-025 In DATA, HREADYOUT=1 with HRESP=0 SHALL complete the transfer:
- cpu_rvalid=1 in the next cycle;
- cpu_rdata = HRDATA captured at that edge, or 0 for writes;
- cpu_err=0;
- return to IDLE.
REQ-026 In DATA, HRESP=1 with HREADYOUT=0 SHALL move to ERR.
- ERR SHALL wait for HREADYOUT=1, then pulse cpu_rvalid=1 with cpu_err=1 and cpu_rdata=0, and return to IDLE.
REQ-027 In DATA, HRESP=1 with HREADYOUT=1 (a non-compliant single-cycle error) SHALL be treated as an error completion, identical to ERR exit.
REQ-028 Wait states SHALL be unbounded; the FSM SHALL hold ADDR or DATA while HREADYOUT=0.
REQ-029 HMASTLOCK SHALL be tied to 0; HREADY SHALL equal HREADYOUT, since the block has a single slave.
REQ-030 cpu_rvalid SHALL be a single-cycle pulse per granted request: exactly one pulse, never two.
REQ-031 Minimum latency SHALL be a grant at cycle 0, address phase at cycle 1, data phase at cycle 2, and cpu_rvalid at cycle 3. A misaligned request SHALL give cpu_rvalid at cycle 1.
REQ-032 If mss_ready falls mid-transfer, the block SHALL finish the transfer and then withhold grants.

Reset
REQ-033 While HRESETn=0, the block SHALL immediately force:
- state IDLE;
- HTRANS=0, HSEL=0, HADDR=FLASH_BASE, HWRITE=0, HSIZE=0, HWDATA=0;
- cpu_rvalid=0, cpu_err=0, cpu_rdata=0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer without any cpu_rvalid pulse; the first grant after release SHALL require mss_ready=1.

Verification
REQ-035 Word read, 0 wait states: mss_ready=1, cpu_addr=0x100, size=2, HRDATA=0xDEADBEEF -> HADDR=0x6000_0100 with NONSEQ at cycle 1; cpu_rvalid at cycle 3, rdata=0xDEADBEEF, err=0.
REQ-036 Halfword write with 3 wait states in the data phase: addr=0x2, wdata=0x0000_1234 -> HSIZE=1, HWRITE=1, HWDATA=0x1234 held for 4 cycles; cpu_rvalid at cycle 6 with err=0.
REQ-037 Misaligned word at addr=0x3 -> no NONSEQ ever driven; cpu_rvalid=1 and cpu_err=1 at cycle 1.
REQ-038 Two-cycle error (HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1) -> cpu_rvalid=1, err=1, rdata=0; the next request is granted the cycle after.
REQ-039 mss_ready=0 with cpu_req=1 for 10 cycles -> cpu_gnt=0 and HTRANS=0 throughout; mss_ready rising -> grant in that same cycle.
REQ-040 HRESETn pulsed low during DATA with HREADYOUT=0 -> outputs at reset values asynchronously; no cpu_rvalid; a normal read after release completes correctly.
